// File: rtl/aes_mem_ctrl.sv
// Memory-to-cipher sequencer: reads plaintext words from the input region, hands 128-bit
// blocks to the cipher, writes ciphertext to the output region and terminates it with SENTINEL.
module aes_mem_ctrl #(
    parameter logic [9:0]  IN_BASE    = 10'd0,
    parameter logic [9:0]  OUT_BASE   = 10'd257,
    parameter int unsigned MAX_WORDS  = 256,
    parameter logic [31:0] SENTINEL   = 32'hDEADBEEF,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         start_in,
    output logic         busy_out,
    output logic         done_out,
    output logic [6:0]   blocks_out,
    output logic [9:0]   mem_rd_addr_out,
    input  logic [31:0]  mem_rd_data_in,
    output logic [9:0]   mem_wr_addr_out,
    output logic [31:0]  mem_wr_data_out,
    output logic [3:0]   mem_we_out,
    output logic [127:0] blk_out,
    output logic         blk_valid_out,
    input  logic         blk_ready_in,
    input  logic [127:0] res_in,
    input  logic         res_valid_in,
    output logic         res_ready_out
);

    typedef enum logic [2:0] {
        StIdle, StRdAddr, StRdWait, StSend, StRecv, StWr, StTerm, StDone
    } state_e;

    localparam logic [9:0] MaxWords = 10'(MAX_WORDS);
    localparam logic [7:0] WaitLast = 8'(RD_LATENCY - 1);

    state_e       state_q, state_d;
    logic [9:0]   word_idx_q, word_idx_d;
    logic [6:0]   blk_idx_q, blk_idx_d;
    logic [1:0]   lane_q, lane_d;
    logic [7:0]   wait_q, wait_d;
    logic         sent_seen_q, sent_seen_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] res_q, res_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [6:0]   blocks_q, blocks_d;
    logic [9:0]   rd_addr_q, rd_addr_d;
    logic [9:0]   wr_addr_q, wr_addr_d;
    logic [31:0]  wr_data_q, wr_data_d;
    logic [3:0]   we_q, we_d;
    logic         blk_valid_q, blk_valid_d;
    logic         res_ready_q, res_ready_d;

    logic [1:0] k;
    logic [1:0] lane_nx;
    logic [6:0] blk_nx;
    logic [9:0] word_nx;

    assign k       = word_idx_q[1:0];
    assign lane_nx = lane_q + 2'd1;
    assign blk_nx  = blk_idx_q + 7'd1;
    assign word_nx = word_idx_q + 10'd1;

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        blk_idx_d   = blk_idx_q;
        lane_d      = lane_q;
        wait_d      = wait_q;
        sent_seen_d = sent_seen_q;
        blk_d       = blk_q;
        res_d       = res_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        blocks_d    = blocks_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        we_d        = 4'h0;
        blk_valid_d = blk_valid_q;
        res_ready_d = res_ready_q;

        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    word_idx_d  = '0;
                    blk_idx_d   = '0;
                    sent_seen_d = 1'b0;
                    busy_d      = 1'b1;
                    rd_addr_d   = IN_BASE;
                    state_d     = StRdAddr;
                end
            end
            StRdAddr: begin
                wait_d  = '0;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (wait_q != WaitLast) begin
                    wait_d = wait_q + 8'd1;
                end else if (mem_rd_data_in == SENTINEL) begin
                    sent_seen_d = 1'b1;
                    if (k != 2'd0) begin
                        for (int j = 1; j < 4; j++) begin
                            if (j >= int'(k)) blk_d[32*j +: 32] = '0;
                        end
                        blk_valid_d = 1'b1;
                        state_d     = StSend;
                    end else begin
                        wr_addr_d = OUT_BASE + {1'b0, blk_idx_q, 2'b00};
                        wr_data_d = SENTINEL;
                        we_d      = 4'hF;
                        state_d   = StTerm;
                    end
                end else begin
                    blk_d[{k, 5'd0} +: 32] = mem_rd_data_in;
                    word_idx_d             = word_nx;
                    if (k == 2'd3 || word_nx == MaxWords) begin
                        blk_valid_d = 1'b1;
                        state_d     = StSend;
                    end else begin
                        rd_addr_d = IN_BASE + word_nx;
                        state_d   = StRdAddr;
                    end
                end
            end
            StSend: begin
                if (blk_ready_in) begin
                    blk_valid_d = 1'b0;
                    res_ready_d = 1'b1;
                    state_d     = StRecv;
                end
            end
            StRecv: begin
                if (res_valid_in) begin
                    res_ready_d = 1'b0;
                    res_d       = res_in;
                    wr_addr_d   = OUT_BASE + {1'b0, blk_idx_q, 2'b00};
                    wr_data_d   = res_in[31:0];
                    we_d        = 4'hF;
                    lane_d      = 2'd0;
                    state_d     = StWr;
                end
            end
            StWr: begin
                if (lane_q != 2'd3) begin
                    lane_d    = lane_nx;
                    wr_addr_d = wr_addr_q + 10'd1;
                    wr_data_d = res_q[{lane_nx, 5'd0} +: 32];
                    we_d      = 4'hF;
                end else begin
                    blk_idx_d = blk_nx;
                    if (sent_seen_q || word_idx_q == MaxWords) begin
                        wr_addr_d = OUT_BASE + {1'b0, blk_nx, 2'b00};
                        wr_data_d = SENTINEL;
                        we_d      = 4'hF;
                        state_d   = StTerm;
                    end else begin
                        rd_addr_d = IN_BASE + word_idx_q;
                        state_d   = StRdAddr;
                    end
                end
            end
            StTerm: begin
                done_d   = 1'b1;
                blocks_d = blk_idx_q;
                state_d  = StDone;
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            word_idx_q  <= '0;
            blk_idx_q   <= '0;
            lane_q      <= '0;
            wait_q      <= '0;
            sent_seen_q <= 1'b0;
            blk_q       <= '0;
            res_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            blocks_q    <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            we_q        <= 4'h0;
            blk_valid_q <= 1'b0;
            res_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            blk_idx_q   <= blk_idx_d;
            lane_q      <= lane_d;
            wait_q      <= wait_d;
            sent_seen_q <= sent_seen_d;
            blk_q       <= blk_d;
            res_q       <= res_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            blocks_q    <= blocks_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            we_q        <= we_d;
            blk_valid_q <= blk_valid_d;
            res_ready_q <= res_ready_d;
        end
    end

    assign busy_out        = busy_q;
    assign done_out        = done_q;
    assign blocks_out      = blocks_q;
    assign mem_rd_addr_out = rd_addr_q;
    assign mem_wr_addr_out = wr_addr_q;
    assign mem_wr_data_out = wr_data_q;
    assign mem_we_out      = we_q;
    assign blk_out         = blk_q;
    assign blk_valid_out   = blk_valid_q;
    assign res_ready_out   = res_ready_q;

endmodule

// File: tb/tb_aes_mem_ctrl.sv
// Randomized bench for aes_mem_ctrl: memory and XOR-cipher models plus a block-level reference.
module tb_aes_mem_ctrl;

    localparam int unsigned MaxWords = 256;
    localparam int unsigned RdLat    = 2;
    localparam logic [31:0] Sent     = 32'hDEADBEEF;
    localparam int          OutBase  = 257;

    logic         clk_in, rst_n_in, start_in;
    logic         busy_out, done_out;
    logic [6:0]   blocks_out;
    logic [9:0]   mem_rd_addr_out, mem_wr_addr_out;
    logic [31:0]  mem_rd_data_in, mem_wr_data_out;
    logic [3:0]   mem_we_out;
    logic [127:0] blk_out, res_in;
    logic         blk_valid_out, blk_ready_in, res_valid_in, res_ready_out;

    aes_mem_ctrl #(
        .IN_BASE(10'd0), .OUT_BASE(10'd257), .MAX_WORDS(MaxWords),
        .SENTINEL(Sent), .RD_LATENCY(RdLat)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
        .busy_out(busy_out), .done_out(done_out), .blocks_out(blocks_out),
        .mem_rd_addr_out(mem_rd_addr_out), .mem_rd_data_in(mem_rd_data_in),
        .mem_wr_addr_out(mem_wr_addr_out), .mem_wr_data_out(mem_wr_data_out),
        .mem_we_out(mem_we_out), .blk_out(blk_out), .blk_valid_out(blk_valid_out),
        .blk_ready_in(blk_ready_in), .res_in(res_in), .res_valid_in(res_valid_in),
        .res_ready_out(res_ready_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Input memory with a fixed read pipeline of RdLat cycles.
    logic [31:0] in_mem [1024];
    logic [31:0] rd_pipe [RdLat];
    always @(posedge clk_in) begin
        rd_pipe[0] <= in_mem[mem_rd_addr_out];
        for (int i = 1; i < RdLat; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd_data_in = rd_pipe[RdLat-1];

    // Environment state owned by the monitor process.
    logic [31:0]  out_mem [1024];
    int           out_gen [1024];
    logic [127:0] got_blks [$];
    int           cyc, done_cnt, wr_cnt, stab_err, ovl_err, we_err;
    // Written only by the main process.
    int           test_id, stall_until;
    logic [127:0] key;
    bit           spur_en;

    initial begin
        bit           pend, real_v, blk_hs, res_hs, prev_wait;
        logic [127:0] pend_data, res_data, blk_seen;
        cyc = 0; done_cnt = 0; wr_cnt = 0; stab_err = 0; ovl_err = 0; we_err = 0;
        for (int i = 0; i < 1024; i++) out_gen[i] = -1;
        blk_ready_in = 1'b0; res_valid_in = 1'b0; res_in = '0;
        pend = 0; real_v = 0; blk_hs = 0; res_hs = 0; prev_wait = 0;
        pend_data = '0; res_data = '0; blk_seen = '0;
        forever begin
            @(negedge clk_in);
            cyc++;
            if (!rst_n_in) begin
                pend = 0; real_v = 0; blk_hs = 0; res_hs = 0; prev_wait = 0;
            end else begin
                if (blk_hs) begin
                    got_blks.push_back(blk_seen);
                    pend      = 1;
                    pend_data = blk_seen ^ key;
                end
                if (res_hs) real_v = 0;
                if (prev_wait && blk_valid_out && blk_out != blk_seen) stab_err++;
                if (blk_valid_out && res_ready_out) ovl_err++;
                if (mem_we_out != 4'h0) begin
                    if (mem_we_out != 4'hF) we_err++;
                    out_mem[mem_wr_addr_out] = mem_wr_data_out;
                    out_gen[mem_wr_addr_out] = test_id;
                    wr_cnt++;
                end
                if (done_out) done_cnt++;
            end
            blk_ready_in = (cyc < stall_until) ? 1'b0 : 1'($urandom_range(0, 1));
            if (pend && !real_v && $urandom_range(0, 2) != 0) begin
                real_v = 1; res_data = pend_data; pend = 0;
            end
            if (real_v) begin
                res_valid_in = 1'b1;
                res_in       = res_data;
            end else if (spur_en && !busy_out) begin
                // Stray results while idle must not be taken.
                res_valid_in = 1'($urandom_range(0, 1));
                res_in       = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                res_valid_in = 1'b0;
            end
            blk_hs    = rst_n_in && blk_valid_out && blk_ready_in;
            prev_wait = rst_n_in && blk_valid_out && !blk_ready_in;
            blk_seen  = blk_out;
            res_hs    = rst_n_in && res_valid_in && res_ready_out;
        end
    end

    int n_cmp, n_bad;
    logic [127:0] exp_blks [$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == Sent) w = 32'h0;
        return w;
    endfunction

    // Reference: chop the input region into 4-word blocks up to the sentinel or capacity.
    function automatic void build_model();
        logic [127:0] cur;
        int lane, idx;
        exp_blks.delete();
        cur = '0; lane = 0; idx = 0;
        while (1) begin
            if (idx == MaxWords || in_mem[idx] == Sent) begin
                if (lane > 0) exp_blks.push_back(cur);
                break;
            end
            cur[32*lane +: 32] = in_mem[idx];
            lane++; idx++;
            if (lane == 4) begin
                exp_blks.push_back(cur);
                cur = '0; lane = 0;
            end
        end
    endfunction

    task automatic run_test(input string name, input bit stall, input bit second_start);
        int base_done, base_wr, base_hs, base_st, base_ov, base_we, nb, bad;
        bit seen;
        logic [127:0] res;
        test_id++;
        build_model();
        nb = exp_blks.size();
        base_done = done_cnt; base_wr = wr_cnt; base_hs = got_blks.size();
        base_st = stab_err; base_ov = ovl_err; base_we = we_err;
        if (stall) stall_until = cyc + 40;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        check_eq({name, ".busy"}, busy_out, 1);
        check_eq({name, ".rd_addr0"}, mem_rd_addr_out, 0);
        if (second_start) begin
            seen = 0;
            for (int i = 0; i < 2000 && !seen; i++) begin
                @(negedge clk_in);
                if (res_ready_out) seen = 1;
            end
            check_eq({name, ".recv_reached"}, seen, 1);
            start_in = 1'b1;
            @(negedge clk_in); start_in = 1'b0;
        end
        seen = 0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk_in);
            if (done_out) seen = 1;
        end
        check_eq({name, ".done_seen"}, seen, 1);
        repeat (3) @(negedge clk_in);
        check_eq({name, ".blocks"}, blocks_out, nb);
        check_eq({name, ".done_pulses"}, done_cnt - base_done, 1);
        check_eq({name, ".busy_end"}, busy_out, 0);
        check_eq({name, ".handshakes"}, got_blks.size() - base_hs, nb);
        for (int b = 0; b < nb && base_hs + b < got_blks.size(); b++)
            check_eq($sformatf("%s.blk%0d", name, b), got_blks[base_hs + b], exp_blks[b]);
        bad = 0;
        for (int b = 0; b < nb; b++) begin
            res = exp_blks[b] ^ key;
            for (int j = 0; j < 4; j++) begin
                if (out_gen[OutBase + 4*b + j] != test_id ||
                    out_mem[OutBase + 4*b + j] != res[32*j +: 32]) bad++;
            end
        end
        check_eq({name, ".out_words_bad"}, bad, 0);
        check_eq({name, ".term_gen"}, out_gen[OutBase + 4*nb], test_id);
        check_eq({name, ".term_word"}, out_mem[OutBase + 4*nb], Sent);
        check_eq({name, ".write_count"}, wr_cnt - base_wr, 4*nb + 1);
        check_eq({name, ".protocol_errs"}, (stab_err - base_st) + (ovl_err - base_ov) +
                 (we_err - base_we), 0);
    endtask

    initial begin
        int n, base_done, base_wr;
        bit seen;
        n_cmp = 0; n_bad = 0; test_id = 0; stall_until = 0; spur_en = 1; key = '0;
        rst_n_in = 1'b0; start_in = 1'b0;
        for (int i = 0; i < 1024; i++) in_mem[i] = rnd_word();
        #12;
        check_eq("rst.busy", busy_out, 0);
        check_eq("rst.done", done_out, 0);
        check_eq("rst.blocks", blocks_out, 0);
        check_eq("rst.we", mem_we_out, 0);
        check_eq("rst.handshake", {blk_valid_out, res_ready_out}, 0);
        check_eq("rst.addrs", {mem_rd_addr_out, mem_wr_addr_out, mem_wr_data_out}, 0);
        check_eq("rst.blk", blk_out, 0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (4) @(negedge clk_in);
        check_eq("idle.busy", busy_out, 0);

        for (int i = 0; i < 8; i++) in_mem[i] = 32'(i + 1);
        in_mem[8] = Sent;
        key = '1;
        run_test("eight", 0, 0);

        key = {$urandom, $urandom, $urandom, $urandom};
        in_mem[0] = rnd_word(); in_mem[1] = rnd_word(); in_mem[2] = Sent;
        run_test("two", 0, 0);

        in_mem[0] = Sent;
        run_test("empty", 0, 0);

        for (int i = 0; i < 256; i++) in_mem[i] = rnd_word();
        run_test("full", 0, 0);
        check_eq("full.last_lane_gen", out_gen[512], test_id);

        for (int i = 0; i < 6; i++) in_mem[i] = rnd_word();
        in_mem[6] = Sent;
        run_test("stall", 1, 1);

        for (int t = 0; t < 4; t++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            n = $urandom_range(0, 24);
            for (int i = 0; i < n; i++) in_mem[i] = rnd_word();
            in_mem[n] = Sent;
            run_test($sformatf("rand%0d", t), 0, 0);
        end

        // Abort during the first result write, then rerun.
        for (int i = 0; i < 8; i++) in_mem[i] = 32'(i + 1);
        in_mem[8] = Sent;
        key = '1;
        base_done = done_cnt;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk_in);
            if (mem_we_out != 4'h0) seen = 1;
        end
        check_eq("abort.wr_reached", seen, 1);
        rst_n_in = 1'b0;
        #1;
        check_eq("abort.we", mem_we_out, 0);
        check_eq("abort.busy", busy_out, 0);
        check_eq("abort.blocks", blocks_out, 0);
        check_eq("abort.outs", {blk_valid_out, res_ready_out, mem_wr_addr_out,
                 mem_rd_addr_out, mem_wr_data_out}, 0);
        check_eq("abort.blk", blk_out, 0);
        base_wr = wr_cnt;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (10) @(negedge clk_in);
        check_eq("abort.no_writes", wr_cnt - base_wr, 0);
        check_eq("abort.no_done", done_cnt - base_done, 0);
        check_eq("abort.idle", busy_out, 0);
        run_test("rerun", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
